ibex_fetch_align_fifo: RTL



---
 rtl/ibex_fetch_pkg.sv | 17 +
 rtl/ibex_fetch_realigner.sv | 48 ++++
 rtl/ibex_fetch_align_fifo.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ibex_fetch_pkg.sv
// Shared types and constants for the fetch-side instruction realignment queue.
// Compressed-instruction support is enabled by defining IBEX_FETCH_ALIGN_RVC_EN.
package ibex_fetch_pkg;

    localparam int unsigned FETCH_FIFO_DEPTH = 3;
    localparam logic [1:0]  OPC_UNCOMPRESSED = 2'b11;

    typedef struct packed {
        logic [31:0] rdata;
        logic        valid;
    } fetch_entry_t;

    function automatic logic is_compressed(input logic [15:0] instr);
        return instr[1:0] != OPC_UNCOMPRESSED;
    endfunction

endpackage

// File: rtl/ibex_fetch_realigner.sv
// Combinational instruction extractor: picks one aligned instruction from the head words.
// The halfword/straddle path exists only when IBEX_FETCH_ALIGN_RVC_EN is defined.
module ibex_fetch_realigner
    import ibex_fetch_pkg::*;
#(
    parameter int unsigned CntW = 3
) (
    input  logic [31:0]     entry0_i,
`ifdef IBEX_FETCH_ALIGN_RVC_EN
    input  logic [31:0]     entry1_i,
    input  logic            half_i,
`endif
    input  logic [CntW-1:0] count_i,
    output logic [31:0]     rdata_o,
    output logic            is_compressed_o,
    output logic [1:0]      needed_words_o,
    output logic            valid_o
);

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        rdata_o         = '0;
        is_compressed_o = 1'b0;
        needed_words_o  = 2'd1;
        if (count_i != '0) begin
`ifdef IBEX_FETCH_ALIGN_RVC_EN
            // NOTE: blocking assignment here, so is_compressed_o is read back with its new value.
            if (!half_i) begin
                is_compressed_o = is_compressed(entry0_i[15:0]);
                rdata_o         = is_compressed_o ? {16'h0000, entry0_i[15:0]} : entry0_i;
            end else begin
                is_compressed_o = is_compressed(entry0_i[31:16]);
                if (is_compressed_o) begin
                    rdata_o = {16'h0000, entry0_i[31:16]};
                end else begin
                    rdata_o        = {entry1_i[15:0], entry0_i[31:16]};
                    needed_words_o = 2'd2;
                end
            end
`else
            rdata_o = entry0_i;
`endif
        end
    end

    assign valid_o = count_i >= CntW'(needed_words_o);

endmodule

// File: rtl/ibex_fetch_align_fifo.sv
// Fetch word queue feeding IF/ID: stores fetched words and emits one aligned instruction
// per handshake, with an empty-queue bypass. RVC realignment under IBEX_FETCH_ALIGN_RVC_EN.
module ibex_fetch_align_fifo
    import ibex_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic [31:0] in_addr_i,
    input  logic [31:0] in_rdata_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o,
    output logic        out_is_compressed_o,
    output logic        out_valid_stored_o
);

    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned LCntW = $clog2(DEPTH + 2);

    fetch_entry_t    entries_q [DEPTH];
    fetch_entry_t    entries_d [DEPTH];
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     addr_q, addr_d;
    logic            addr_known_q, addr_known_d;

    logic             in_push;
    logic [LCntW-1:0] list_count;
    logic [31:0]      entry0;
    logic [1:0]       needed_words;
    logic             handshake;
    logic [31:0]      next_addr;
    logic             pop;
    logic             pop_stored;
    logic             push_store;
    logic [CntW-1:0]  wr_idx;

    assign in_push    = in_valid_i & ~clear_i;
    assign list_count = LCntW'(count_q) + LCntW'(in_push);
    assign entry0     = entries_q[0].valid ? entries_q[0].rdata : in_rdata_i;

`ifdef IBEX_FETCH_ALIGN_RVC_EN
    logic [31:0] entry1;
    logic        unused_addr_lsb;

    // With one stored word the input word is the second list entry.
    assign entry1          = entries_q[1].valid ? entries_q[1].rdata : in_rdata_i;
    assign out_addr_o      = addr_known_q ? addr_q : {in_addr_i[31:1], 1'b0};
    assign unused_addr_lsb = in_addr_i[0];
`else
    logic unused_addr_lsbs;

    assign out_addr_o       = addr_known_q ? addr_q : {in_addr_i[31:2], 2'b00};
    assign unused_addr_lsbs = ^in_addr_i[1:0];
`endif

    ibex_fetch_realigner #(
        .CntW (LCntW)
    ) u_realigner (
        .entry0_i        (entry0),
`ifdef IBEX_FETCH_ALIGN_RVC_EN
        .entry1_i        (entry1),
        .half_i          (out_addr_o[1]),
`endif
        .count_i         (list_count),
        .rdata_o         (out_rdata_o),
        .is_compressed_o (out_is_compressed_o),
        .needed_words_o  (needed_words),
        .valid_o         (out_valid_o)
    );

    assign out_valid_stored_o = (count_q != '0) && (count_q >= CntW'(needed_words));
    assign in_ready_o         = count_q <= CntW'(DEPTH - 2);

    assign handshake = out_valid_o & out_ready_i;
    assign next_addr = out_addr_o + (out_is_compressed_o ? 32'd2 : 32'd4);
`ifdef IBEX_FETCH_ALIGN_RVC_EN
    assign pop = handshake & ~next_addr[1];
`else
    assign pop = handshake;
`endif

    // A pop with nothing stored consumes the bypassed input word, which is then never written.
    assign pop_stored = pop & (count_q != '0);
    assign push_store = in_push & ~(pop & (count_q == '0));
    assign wr_idx     = count_q - CntW'(pop_stored);

    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        if (clear_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
            count_d = '0;
        end else begin
            if (pop_stored) begin
                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    entries_d[i] = entries_q[i + 1];
                end
                entries_d[DEPTH-1] = '0;
                count_d            = count_q - CntW'(1);
            end
            if (push_store && (wr_idx < CntW'(DEPTH))) begin
                entries_d[wr_idx] = '{rdata: in_rdata_i, valid: 1'b1};
                count_d           = count_d + CntW'(1);
            end
        end
    end

    always_comb begin
        addr_d       = addr_q;
        addr_known_d = addr_known_q;
        if (clear_i) begin
            addr_known_d = 1'b0;
        end else if (handshake) begin
            addr_d       = next_addr;
            addr_known_d = 1'b1;
        end else if (in_push && !addr_known_q) begin
            addr_d       = out_addr_o;
            addr_known_d = 1'b1;
        end
    end

    // NOTE: the storage is a handful of flops, so data is reset along with the valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q      <= '0;
            addr_q       <= '0;
            addr_known_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge state.
            entries_q    <= entries_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            addr_known_q <= addr_known_d;
        end
    end

    // The prefetch buffer may only have one word in flight beyond in_ready_o.
    assert property (@(posedge clk) disable iff (!rst_n)
        in_valid_i |-> (count_q != CntW'(DEPTH)));

endmodule
